sc_stream_gen: RTL and testbench



---
 rtl/sc_pkg.sv | 37 +++
 rtl/sc_lane.sv | 56 +++++
 rtl/sc_stream_gen.sv | 100 ++++++++++
 tb/tb_sc_stream_gen.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// Shared types and helpers for the stochastic stream generator.
// Optional LFSR random sources are enabled with SC_LFSR_EN.
package sc_pkg;

  typedef enum logic [1:0] {IDLE, RUN, ACT} sc_state_e;

  localparam int ACT_CYCLES = 2;

  // Maximal-length Fibonacci feedback taps (bit i set = stage i+1 tapped).
  function automatic logic [15:0] lfsr_taps(input int bw);
    case (bw)
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      default: return 16'hD008;
    endcase
  endfunction

  // Reverse the low bw bits of v.
  function automatic logic [15:0] bitrev(input logic [15:0] v, input int bw);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      if (i < bw) r[i] = v[bw-1-i];
    return r;
  endfunction

endpackage

// File: rtl/sc_lane.sv
// One stream lane: operand register, comparator and, with SC_LFSR_EN,
// a per-lane LFSR random source reseeded on every accept.
module sc_lane
  import sc_pkg::*;
#(
  parameter int BITWIDTH = 8,
  parameter int LANE     = 0,
  parameter int SEED     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                run,
  input  logic [BITWIDTH-1:0] bin_val,
  input  logic [BITWIDTH-1:0] rnd,
  output logic                sc
);

  logic [BITWIDTH-1:0] op, op_n, r_n;

  assign op_n = load ? bin_val : op;

`ifdef SC_LFSR_EN
  localparam logic [15:0] TAPS = lfsr_taps(BITWIDTH);
  localparam int SEED_RAW = (SEED + 37 * LANE) % (1 << BITWIDTH);
  localparam logic [BITWIDTH-1:0] SEED_K =
    (SEED_RAW == 0) ? BITWIDTH'(1) : BITWIDTH'(SEED_RAW);

  logic [BITWIDTH-1:0] lfsr;

  always_comb begin
    r_n = lfsr;
    if (load)     r_n = SEED_K;
    else if (run) r_n = {lfsr[BITWIDTH-2:0], ^(lfsr & TAPS[BITWIDTH-1:0])};
  end

  always_ff @(posedge clk) begin
    if (reset) lfsr <= SEED_K;
    else       lfsr <= r_n;
  end
`else
  assign r_n = rnd;
`endif

  // Compare against next-cycle operand/random so the bit lines up with cnt_en.
  always_ff @(posedge clk) begin
    if (reset) begin
      op <= '0;
      sc <= 1'b0;
    end else begin
      op <= op_n;
      sc <= run && (op_n > r_n);
    end
  end

endmodule

// File: rtl/sc_stream_gen.sv
// Binary-to-stochastic stream generator: FSM, step counter and shared
// bit-reversed counter source. SC_LFSR_EN selects per-lane LFSR sources.
module sc_stream_gen
  import sc_pkg::*;
#(
  parameter int BITWIDTH = 8,
  parameter int NO_SNG   = 4,
  parameter int MAX_SHFT = 4,
  parameter int SEED     = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NO_SNG*BITWIDTH-1:0]   bin_vals,
  input  logic [$clog2(MAX_SHFT+1)-1:0] shft_amt,
  output logic [NO_SNG-1:0]            sc_vals,
  output logic                         cnt_en,
  output logic                         act_en,
  output logic                         done
);

  localparam int SW = $clog2(MAX_SHFT + 1);
  localparam logic [BITWIDTH-1:0] ALL_ONES = '1;

  sc_state_e           state, state_n;
  logic [BITWIDTH-1:0] step, step_n, last_step, rnd;
  logic [SW-1:0]       shft, shft_n, shft_clamp;
  logic [1:0]          act_cnt, act_cnt_n;
  logic                accept, run_n;

  assign in_ready   = (state == IDLE) && !reset;
  assign accept     = in_valid && in_ready;
  assign shft_clamp = (shft_amt > SW'(MAX_SHFT)) ? SW'(MAX_SHFT) : shft_amt;
  // Run length 2^(BITWIDTH-s): last step index is an all-ones mask.
  assign last_step  = ALL_ONES >> shft;

  always_comb begin
    state_n   = state;
    step_n    = step;
    shft_n    = shft;
    act_cnt_n = act_cnt;
    case (state)
      IDLE: if (accept) begin
        state_n = RUN;
        step_n  = '0;
        shft_n  = shft_clamp;
      end
      RUN: if (step == last_step) begin
        state_n   = ACT;
        act_cnt_n = '0;
      end else begin
        step_n = step + 1'b1;
      end
      ACT: if (act_cnt == 2'(ACT_CYCLES - 1)) state_n = IDLE;
           else act_cnt_n = act_cnt + 1'b1;
      default: state_n = IDLE;
    endcase
  end

  assign run_n = (state_n == RUN);
  assign rnd   = BITWIDTH'(bitrev(16'(step_n), BITWIDTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      step    <= '0;
      shft    <= '0;
      act_cnt <= '0;
      cnt_en  <= 1'b0;
      act_en  <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      step    <= step_n;
      shft    <= shft_n;
      act_cnt <= act_cnt_n;
      cnt_en  <= run_n;
      act_en  <= (state_n == ACT);
      done    <= (state_n == ACT) && (act_cnt_n == 2'(ACT_CYCLES - 1));
    end
  end

  for (genvar k = 0; k < NO_SNG; k++) begin : g_lane
    sc_lane #(
      .BITWIDTH(BITWIDTH),
      .LANE    (k),
      .SEED    (SEED)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .load   (accept),
      .run    (run_n),
      .bin_val(bin_vals[k*BITWIDTH +: BITWIDTH]),
      .rnd    (rnd),
      .sc     (sc_vals[k])
    );
  end

endmodule

// File: tb/tb_sc_stream_gen.sv
// Self-checking bench for sc_stream_gen: directed and random transactions
// scored against run length, phase timing and per-lane ones counts.
module tb_sc_stream_gen;

  localparam int BW = 8;
  localparam int NL = 4;
  localparam int MS = 4;
  localparam int SW = $clog2(MS + 1);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [NL*BW-1:0]  bin_vals = '0;
  logic [SW-1:0]     shft_amt = '0;
  logic [NL-1:0]     sc_vals;
  logic              cnt_en, act_en, done;

  int n_chk = 0;
  int n_err = 0;
  int last_ones[NL];
  bit [255:0] cap[NL];

  always #5 clk = ~clk;

  sc_stream_gen #(.BITWIDTH(BW), .NO_SNG(NL), .MAX_SHFT(MS), .SEED(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .bin_vals(bin_vals),
    .shft_amt(shft_amt),
    .sc_vals (sc_vals),
    .cnt_en  (cnt_en),
    .act_en  (act_en),
    .done    (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_txn(input int ops[NL], input int s);
    for (int k = 0; k < NL; k++) bin_vals[k*BW +: BW] = BW'(ops[k]);
    shft_amt = SW'(s);
    in_valid = 1'b1;
  endtask

  // Expects inputs already presented with in_ready high; accept is the next edge.
  task automatic check_txn(input int ops[NL], input int s, input bit hold);
    int se, len, cnt_cyc, first_cnt, last_cnt, act_cyc, first_act;
    int done_n, done_cyc, ready_cyc, stray;
    int ones[NL];
    se = (s > MS) ? MS : s;
    len = 1 << (BW - se);
    cnt_cyc = 0; first_cnt = -1; last_cnt = -1; act_cyc = 0; first_act = -1;
    done_n = 0; done_cyc = -1; ready_cyc = -1; stray = 0;
    for (int k = 0; k < NL; k++) begin ones[k] = 0; cap[k] = '0; end
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
    for (int c = 1; c <= 600; c++) begin
      if (cnt_en) begin
        if (first_cnt < 0) first_cnt = c;
        if (cnt_cyc < 256)
          for (int k = 0; k < NL; k++) cap[k][cnt_cyc] = sc_vals[k];
        cnt_cyc++;
        last_cnt = c;
      end else if (sc_vals != '0) stray++;
      for (int k = 0; k < NL; k++) ones[k] += int'(sc_vals[k]);
      if (act_en) begin
        act_cyc++;
        if (first_act < 0) first_act = c;
      end
      if (done) begin done_n++; done_cyc = c; end
      if (in_ready) begin ready_cyc = c; break; end
      if (hold) begin
        bin_vals = $urandom();
        shft_amt = SW'($urandom_range(0, 7));
      end
      @(posedge clk); #1;
    end
    chk("cnt_len", cnt_cyc, len);
    chk("cnt_first", first_cnt, 1);
    chk("cnt_last", last_cnt, len);
    chk("sc_outside_run", stray, 0);
    chk("act_len", act_cyc, 2);
    chk("act_first", first_act, len + 1);
    chk("done_count", done_n, 1);
    chk("done_cycle", done_cyc, len + 2);
    chk("ready_cycle", ready_cyc, len + 3);
    for (int k = 0; k < NL; k++) begin
      last_ones[k] = ones[k];
`ifdef SC_LFSR_EN
      if (ops[k] == 0) chk($sformatf("zero_lane%0d", k), ones[k], 0);
`else
      chk($sformatf("ones_lane%0d", k), ones[k], (ops[k] + (1 << se) - 1) >> se);
`endif
    end
  endtask

  initial begin
    int o[NL];
    int o2[NL];
    bit [255:0] ref_bits;

    // Reset held 3 cycles, then a quiet idle period.
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", in_ready, 0);
    chk("rst_outs", {sc_vals, cnt_en, act_en, done}, 0);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 20; i++) begin
      chk("idle_outs", {sc_vals, cnt_en, act_en, done}, 0);
      chk("idle_ready", in_ready, 1);
      @(posedge clk); #1;
    end

`ifdef SC_LFSR_EN
    o = '{0, 200, 17, 99};
    start_txn(o, 0);
    check_txn(o, 0, 1'b0);
    ref_bits = cap[1];
    chk("lfsr_zero_lane0", int'(cap[0] != '0), 0);
    chk("lfsr_ones_range", int'(last_ones[1] >= 190 && last_ones[1] <= 210), 1);
    repeat (3) @(posedge clk);
    #1;
    start_txn(o, 0);
    check_txn(o, 0, 1'b0);
    chk("lfsr_repeatable", int'(cap[1] == ref_bits), 1);
`else
    o = '{128, 64, 255, 0};
    start_txn(o, 0);
    check_txn(o, 0, 1'b0);

    o = '{100, 1, 16, 17};
    start_txn(o, 4);
    check_txn(o, 4, 1'b0);
    ref_bits = cap[0];
    start_txn(o, 7);
    check_txn(o, 7, 1'b0);
    chk("clamp_same_stream", int'(cap[0] == ref_bits), 1);

    // Reset while step 50 is on the outputs.
    o = '{200, 255, 3, 90};
    start_txn(o, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    chk("mid_run_cnt_en", cnt_en, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_outs", {sc_vals, cnt_en, act_en, done}, 0);
    chk("mid_rst_ready", in_ready, 1);
    o = '{37, 0, 255, 128};
    start_txn(o, 0);
    check_txn(o, 0, 1'b0);

    // in_valid held through a busy period; second word taken in first idle cycle.
    o  = '{10, 20, 30, 250};
    o2 = '{77, 5, 200, 1};
    start_txn(o, 2);
    check_txn(o, 2, 1'b1);
    start_txn(o2, 3);
    check_txn(o2, 3, 1'b0);

    for (int t = 0; t < 6; t++) begin
      int s;
      for (int k = 0; k < NL; k++)
        case ($urandom_range(0, 5))
          0:       o[k] = 0;
          1:       o[k] = 255;
          default: o[k] = int'($urandom_range(0, 255));
        endcase
      s = int'($urandom_range(0, 7));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      start_txn(o, s);
      check_txn(o, s, 1'b0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
